ddr5_device_responder: RTL and testbench

Cycle-accurate DDR5 device-side model answering the memory scheduler's command stream. It decodes ACT/RD/WR/PRE/REF per bank and enforces the same timing parameters the scheduler counts down. It returns deterministic read-data bursts and opens write-data windows. Every timing or protocol violation is reported with a code, and an offending command causes no state change.

---
 rtl/ddr5_device_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_ddr5_device_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ddr5_device_responder.sv
// DDR5 device-side responder: per-bank timing checks, read bursts, write windows, violation codes.
// Build option: define DDR5_RESP_VIOL_CNT_EN to build the saturating violation counter.
//
// bank state | meaning
// B_IDLE     | no row open
// B_OPENING  | ACT issued, waiting out tRCD (main_cnt)
// B_ACTIVE   | row open, RD/WR/PRE accepted
// B_CLOSING  | PRE issued, waiting out tRP (main_cnt)
module ddr5_device_responder #(
  parameter int NUM_BANKS = 32,
  parameter int ROW_W     = 16,
  parameter int COL_W     = 10,
  parameter int tRCD      = 39,
  parameter int tRP       = 39,
  parameter int tRAS      = 76,
  parameter int tCL       = 40,
  parameter int tCWD      = 38,
  parameter int tBURST    = 8,
  parameter int tWR       = 72,
  parameter int tRTP      = 18,
  parameter int tRFC      = 295
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [2:0]                   cmd,
  input  logic [$clog2(NUM_BANKS)-1:0] cmd_bank,
  input  logic [ROW_W-1:0]             cmd_row,
  input  logic [COL_W-1:0]             cmd_col,
  output logic                         rdata_valid,
  output logic [63:0]                  rdata,
  output logic                         wr_window,
  output logic                         viol,
  output logic [3:0]                   viol_code,
  output logic                         refresh_busy,
  output logic [15:0]                  viol_count
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam logic [2:0] CMD_NOP = 3'd0, CMD_ACT = 3'd1, CMD_RD = 3'd2,
                         CMD_WR  = 3'd3, CMD_PRE = 3'd4, CMD_REF = 3'd5;
  // Write recovery is measured from the last write beat, hence the -2.
  localparam logic [9:0] RCD_LD = 10'(tRCD - 1), RP_LD = 10'(tRP - 1), RAS_LD = 10'(tRAS - 1),
                         RTP_LD = 10'(tRTP - 1), WR_LD = 10'(tCWD + tBURST + tWR - 2),
                         RFC_LD = 10'(tRFC), CL_LD = 10'(tCL - 2), CWD_LD = 10'(tCWD - 2),
                         BURST_LAST = 10'(tBURST - 1);

  typedef enum logic [1:0] {B_IDLE, B_OPENING, B_ACTIVE, B_CLOSING} bank_state_t;
  typedef enum logic [1:0] {BUS_IDLE, BUS_WAIT, BUS_BURST} bus_state_t;

  bank_state_t      bank_st  [NUM_BANKS], bank_st_n  [NUM_BANKS];
  logic [9:0]       main_cnt [NUM_BANKS], main_cnt_n [NUM_BANKS];
  logic [9:0]       ras_cnt  [NUM_BANKS], ras_cnt_n  [NUM_BANKS];
  logic [9:0]       pre_gate [NUM_BANKS], pre_gate_n [NUM_BANKS];
  logic [ROW_W-1:0] open_row [NUM_BANKS], open_row_n [NUM_BANKS];
  logic [NUM_BANKS-1:0] eff_idle, eff_active;
  logic             any_open, is_col, cmd_ok, viol_n;
  logic [3:0]       code_n;
  logic [9:0]       ref_cnt, ref_cnt_n;

  bus_state_t       bus_st, bus_st_n;
  logic [9:0]       dly_cnt, dly_cnt_n, beat_cnt, beat_cnt_n;
  logic             bus_rd, bus_rd_n;
  logic [BANK_W-1:0] bus_bank, bus_bank_n;
  logic [ROW_W-1:0] bus_row, bus_row_n;
  logic [COL_W-1:0] bus_col, bus_col_n;

  function automatic logic [9:0] dec(input logic [9:0] v);
    return (v == 10'd0) ? 10'd0 : v - 10'd1;
  endfunction

  // A bank whose counter already hit 0 is treated as having completed its transition.
  always_comb begin
    eff_idle   = '0;
    eff_active = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      eff_idle[b]   = (bank_st[b] == B_IDLE)   || (bank_st[b] == B_CLOSING && main_cnt[b] == 10'd0);
      eff_active[b] = (bank_st[b] == B_ACTIVE) || (bank_st[b] == B_OPENING && main_cnt[b] == 10'd0);
    end
  end

  assign any_open = ~(&eff_idle);
  assign is_col   = (cmd == CMD_RD) || (cmd == CMD_WR);

  always_comb begin
    code_n = 4'd0;
    viol_n = 1'b0;
    if (cmd != CMD_NOP) begin
      viol_n = 1'b1;
      if (ref_cnt > 10'd1)                                   code_n = 4'd5;
      else if (cmd > CMD_REF)                                code_n = 4'd7;
      else if (cmd == CMD_ACT && !eff_idle[cmd_bank])        code_n = 4'd1;
      else if (is_col && !eff_active[cmd_bank])              code_n = 4'd2;
      else if (is_col && bus_st != BUS_IDLE)                 code_n = 4'd4;
      else if (cmd == CMD_PRE && !eff_idle[cmd_bank] &&
               (!eff_active[cmd_bank] || ras_cnt[cmd_bank] != 10'd0 ||
                pre_gate[cmd_bank] != 10'd0))                code_n = 4'd3;
      else if (cmd == CMD_REF && any_open)                   code_n = 4'd6;
      else                                                   viol_n = 1'b0;
    end
    cmd_ok    = (cmd != CMD_NOP) && !viol_n;
    ref_cnt_n = (cmd_ok && cmd == CMD_REF) ? RFC_LD : dec(ref_cnt);
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_st_n[b]  = bank_st[b];
      main_cnt_n[b] = dec(main_cnt[b]);
      ras_cnt_n[b]  = dec(ras_cnt[b]);
      pre_gate_n[b] = dec(pre_gate[b]);
      open_row_n[b] = open_row[b];
      if (bank_st[b] == B_OPENING && main_cnt[b] == 10'd0) bank_st_n[b] = B_ACTIVE;
      if (bank_st[b] == B_CLOSING && main_cnt[b] == 10'd0) bank_st_n[b] = B_IDLE;
    end
    if (cmd_ok) begin
      case (cmd)
        CMD_ACT: begin
          bank_st_n[cmd_bank]  = B_OPENING;
          main_cnt_n[cmd_bank] = RCD_LD;
          ras_cnt_n[cmd_bank]  = RAS_LD;
          open_row_n[cmd_bank] = cmd_row;
        end
        CMD_RD:
          if (pre_gate_n[cmd_bank] < RTP_LD) pre_gate_n[cmd_bank] = RTP_LD;
        CMD_WR:
          if (pre_gate_n[cmd_bank] < WR_LD) pre_gate_n[cmd_bank] = WR_LD;
        CMD_PRE:
          if (eff_active[cmd_bank]) begin
            bank_st_n[cmd_bank]  = B_CLOSING;
            main_cnt_n[cmd_bank] = RP_LD;
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus_st_n   = bus_st;
    dly_cnt_n  = dly_cnt;
    beat_cnt_n = beat_cnt;
    bus_rd_n   = bus_rd;
    bus_bank_n = bus_bank;
    bus_row_n  = bus_row;
    bus_col_n  = bus_col;
    case (bus_st)
      BUS_WAIT:
        if (dly_cnt == 10'd0) begin
          bus_st_n   = BUS_BURST;
          beat_cnt_n = 10'd0;
        end else begin
          dly_cnt_n = dly_cnt - 10'd1;
        end
      BUS_BURST:
        if (beat_cnt == BURST_LAST) bus_st_n = BUS_IDLE;
        else                        beat_cnt_n = beat_cnt + 10'd1;
      default: ;
    endcase
    if (cmd_ok && is_col) begin
      bus_rd_n   = (cmd == CMD_RD);
      bus_bank_n = cmd_bank;
      bus_row_n  = open_row[cmd_bank];
      bus_col_n  = cmd_col;
      beat_cnt_n = 10'd0;
      dly_cnt_n  = (cmd == CMD_RD) ? CL_LD : CWD_LD;
      if ((cmd == CMD_RD && tCL <= 1) || (cmd == CMD_WR && tCWD <= 1)) bus_st_n = BUS_BURST;
      else                                                              bus_st_n = BUS_WAIT;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_st[b]  <= B_IDLE;
        main_cnt[b] <= '0;
        ras_cnt[b]  <= '0;
        pre_gate[b] <= '0;
        open_row[b] <= '0;
      end
      ref_cnt   <= '0;
      viol      <= 1'b0;
      viol_code <= '0;
      bus_st    <= BUS_IDLE;
      dly_cnt   <= '0;
      beat_cnt  <= '0;
      bus_rd    <= 1'b0;
      bus_bank  <= '0;
      bus_row   <= '0;
      bus_col   <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_st[b]  <= bank_st_n[b];
        main_cnt[b] <= main_cnt_n[b];
        ras_cnt[b]  <= ras_cnt_n[b];
        pre_gate[b] <= pre_gate_n[b];
        open_row[b] <= open_row_n[b];
      end
      ref_cnt <= ref_cnt_n;
      viol    <= viol_n;
      if (viol_n) viol_code <= code_n;
      bus_st   <= bus_st_n;
      dly_cnt  <= dly_cnt_n;
      beat_cnt <= beat_cnt_n;
      bus_rd   <= bus_rd_n;
      bus_bank <= bus_bank_n;
      bus_row  <= bus_row_n;
      bus_col  <= bus_col_n;
    end
  end

  assign refresh_busy = (ref_cnt != 10'd0);
  assign rdata_valid  = (bus_st == BUS_BURST) && bus_rd;
  assign wr_window    = (bus_st == BUS_BURST) && !bus_rd;
  assign rdata        = rdata_valid ? {8'(bus_bank), 8'(beat_cnt), 16'(bus_row), 16'(bus_col), 16'hA5A5}
                                    : 64'd0;

`ifdef DDR5_RESP_VIOL_CNT_EN
  logic [15:0] viol_cnt_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                               viol_cnt_q <= '0;
    else if (viol_n && viol_cnt_q != 16'hFFFF) viol_cnt_q <= viol_cnt_q + 16'd1;
  end
  assign viol_count = viol_cnt_q;
`else
  assign viol_count = 16'd0;
`endif

endmodule

// File: tb/tb_ddr5_device_responder.sv
// Directed bench for ddr5_device_responder; read beats are checked against a queue of expected beats.
module tb_ddr5_device_responder;
  localparam int TCL = 40, TCWD = 38, TBURST = 8, TRFC = 295;
  localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4, REF = 3'd5;

  logic        clock, reset_n;
  logic [2:0]  cmd;
  logic [4:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        rdata_valid, wr_window, viol, refresh_busy;
  logic [63:0] rdata;
  logic [3:0]  viol_code;
  logic [15:0] viol_count;

  ddr5_device_responder dut (
    .clock(clock), .reset_n(reset_n), .cmd(cmd), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
    .cmd_col(cmd_col), .rdata_valid(rdata_valid), .rdata(rdata), .wr_window(wr_window),
    .viol(viol), .viol_code(viol_code), .refresh_busy(refresh_busy), .viol_count(viol_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0, failures = 0, exp_viols = 0, t0 = 0, exp_cnt = 0;
  typedef struct { int cyc; logic [63:0] data; } beat_t;
  beat_t exp_q[$];
  beat_t mon_e;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Idle so that the next sampling edge is t0+rel.
  task automatic at(int rel);
    cmd = NOP;
    while (cyc + 1 < t0 + rel) step();
  endtask

  // Advance into cycle c (the interval after edge t0+c-1).
  task automatic wait_cycle(int c);
    while (cyc < t0 + c - 1) step();
  endtask

  task automatic new_scene(int gap);
    repeat (gap) step();
    t0 = cyc + 1;
  endtask

  task automatic do_cmd(string tag, logic [2:0] c, int b, logic [15:0] row, logic [9:0] col,
                        logic [3:0] exp_code);
    cmd = c; cmd_bank = 5'(b); cmd_row = row; cmd_col = col;
    step();
    cmd = NOP;
    check({tag, "_viol"}, 64'(viol), 64'(exp_code != 4'd0));
    if (exp_code != 4'd0) begin
      exp_viols++;
      check({tag, "_code"}, 64'(viol_code), 64'(exp_code));
    end
  endtask

  task automatic push_rd(int b, logic [15:0] row, logic [9:0] col);
    for (int i = 0; i < TBURST; i++)
      exp_q.push_back('{cyc + TCL - 1 + i, {8'(b), 8'(i), row, 6'd0, col, 16'hA5A5}});
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_rdata_valid"}, 64'(rdata_valid), 64'd0);
    check({tag, "_rdata"}, rdata, 64'd0);
    check({tag, "_wr_window"}, 64'(wr_window), 64'd0);
    check({tag, "_viol"}, 64'(viol), 64'd0);
    check({tag, "_viol_code"}, 64'(viol_code), 64'd0);
    check({tag, "_refresh_busy"}, 64'(refresh_busy), 64'd0);
    check({tag, "_viol_count"}, 64'(viol_count), 64'd0);
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (rdata_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", rdata, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("beat_data", rdata, mon_e.data);
        end
      end else if (rdata !== 64'd0) begin
        check("rdata_idle", rdata, 64'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; cmd = NOP; cmd_bank = '0; cmd_row = '0; cmd_col = '0;
    #12;
    check_outputs_zero("reset");
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // read burst contents and timing
    new_scene(2);
    at(0);   do_cmd("rd_act", ACT, 3, 16'h1234, 10'h000, 4'd0);
    at(39);  do_cmd("rd_rd",  RD,  3, 16'h0000, 10'h010, 4'd0);
    push_rd(3, 16'h1234, 10'h010);
    at(100); do_cmd("rd_pre", PRE, 3, 16'h0000, 10'h000, 4'd0);
    check("rd_drained", 64'(exp_q.size()), 64'd0);

    // early column command
    new_scene(45);
    at(0);   do_cmd("early_act", ACT, 0, 16'h0ABC, 10'h000, 4'd0);
    at(38);  do_cmd("early_rd",  RD,  0, 16'h0000, 10'h011, 4'd2);
    at(39);  do_cmd("ontime_rd", RD,  0, 16'h0000, 10'h011, 4'd0);
    push_rd(0, 16'h0ABC, 10'h011);
    at(100); do_cmd("early_pre", PRE, 0, 16'h0000, 10'h000, 4'd0);
    check("early_drained", 64'(exp_q.size()), 64'd0);

    // write window and write recovery
    new_scene(45);
    at(0);   do_cmd("wr_act", ACT, 7, 16'h0042, 10'h000, 4'd0);
    at(39);  do_cmd("wr_wr",  WR,  7, 16'h0000, 10'h005, 4'd0);
    for (int c = 76; c <= 85; c++) begin
      wait_cycle(c);
      check("wr_window", 64'(wr_window), 64'((c >= 39 + TCWD) && (c <= 39 + TCWD + TBURST - 1)));
    end
    at(155); do_cmd("wr_pre_early", PRE, 7, 16'h0000, 10'h000, 4'd3);
    at(156); do_cmd("wr_pre_ok",    PRE, 7, 16'h0000, 10'h000, 4'd0);
    at(194); do_cmd("rp_act_early", ACT, 7, 16'h0043, 10'h000, 4'd1);
    at(195); do_cmd("rp_act_ok",    ACT, 7, 16'h0043, 10'h000, 4'd0);
    at(271); do_cmd("wr_close",     PRE, 7, 16'h0000, 10'h000, 4'd0);

    // refresh with an open bank
    new_scene(45);
    at(0);  do_cmd("ref_open_act", ACT, 5, 16'h0555, 10'h000, 4'd0);
    at(40); do_cmd("ref_open",     REF, 0, 16'h0000, 10'h000, 4'd6);
    at(80); do_cmd("ref_open_pre", PRE, 5, 16'h0000, 10'h000, 4'd0);

    // refresh busy window
    new_scene(45);
    wait_cycle(10);
    check("ref_busy_before", 64'(refresh_busy), 64'd0);
    at(10);  do_cmd("ref_ok", REF, 0, 16'h0000, 10'h000, 4'd0);
    check("ref_busy_first", 64'(refresh_busy), 64'd1);
    at(200); do_cmd("ref_busy_act", ACT, 2, 16'h0222, 10'h000, 4'd5);
    wait_cycle(202);
    check("viol_pulse_end", 64'(viol), 64'd0);
    check("viol_code_hold", 64'(viol_code), 64'd5);
    wait_cycle(10 + TRFC);
    check("ref_busy_last", 64'(refresh_busy), 64'd1);
    at(305); do_cmd("ref_done_act", ACT, 2, 16'h0222, 10'h000, 4'd0);
    check("ref_busy_after", 64'(refresh_busy), 64'd0);
    at(306); do_cmd("undef_cmd", 3'd6, 0, 16'h0000, 10'h000, 4'd7);

    // data-bus conflict
    new_scene(5);
    at(0);  do_cmd("bus_act", ACT, 1, 16'h0111, 10'h000, 4'd0);
    at(39); do_cmd("bus_rd1", RD,  1, 16'h0000, 10'h020, 4'd0);
    push_rd(1, 16'h0111, 10'h020);
    at(39 + TCL + TBURST - 1); do_cmd("bus_rd2_early", RD, 2, 16'h0000, 10'h030, 4'd4);
    at(39 + TCL + TBURST);     do_cmd("bus_rd2_ok",    RD, 2, 16'h0000, 10'h030, 4'd0);
    push_rd(2, 16'h0222, 10'h030);
    wait_cycle(140);
    check("bus_drained", 64'(exp_q.size()), 64'd0);

`ifdef DDR5_RESP_VIOL_CNT_EN
    exp_cnt = exp_viols;
`else
    exp_cnt = 0;
`endif
    check("viol_count", 64'(viol_count), 64'(exp_cnt));

    // reset in the middle of a read burst
    new_scene(5);
    at(0); do_cmd("rst_rd", RD, 1, 16'h0000, 10'h040, 4'd0);
    push_rd(1, 16'h0111, 10'h040);
    wait_cycle(TCL + 2);
    check("mid_burst_valid", 64'(rdata_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    exp_q.delete();
    repeat (2) step();
    reset_n = 1'b1;
    new_scene(1);
    at(0); do_cmd("post_rst_act1", ACT, 1, 16'h0777, 10'h000, 4'd0);
    at(1); do_cmd("post_rst_act9", ACT, 9, 16'h0999, 10'h000, 4'd0);
    check("post_rst_viol_count", 64'(viol_count), 64'd0);
    wait_cycle(60);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
